// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one 1-cycle-latency RAM between fetch and data ports.
// Data has priority, and a starvation counter forces a waiting fetch through.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [2:0]        starve_cnt
);
  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_D_RD, TAG_D_WR} tag_t;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
  tag_t tag, tag_nxt;
  logic [31:0] i_hold, d_hold;
  logic force_i, i_win, d_win;
  logic unused_addr;
  assign unused_addr = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0], d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};
  always_comb begin
    force_i = i_req_valid && starve_cnt == LIMIT;
    i_win = !reset && i_req_valid && (!d_req_valid || force_i);
    d_win = !reset && d_req_valid && !force_i;
    i_req_ready = i_win;
    d_req_ready = d_win;
    mem_en = i_win || d_win;
    mem_addr = d_win ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
    mem_we = (d_win && d_we) ? d_wstrb : 4'b0;
    mem_wdata = d_wdata;
    tag_nxt = d_win ? (d_we ? TAG_D_WR : TAG_D_RD) : (i_win ? TAG_IF : TAG_NONE);
    // reset suppresses responses to an access issued just before it
    i_rvalid = !reset && tag == TAG_IF;
    d_rvalid = !reset && (tag == TAG_D_RD || tag == TAG_D_WR);
    i_rdata = reset ? 32'd0 : (i_rvalid ? mem_rdata : i_hold);
    d_rdata = reset ? 32'd0 : ((d_rvalid && tag == TAG_D_RD) ? mem_rdata : d_hold);
  end
  always_ff @(posedge clk) begin
    tag <= reset ? TAG_NONE : tag_nxt;
    i_hold <= i_rdata;
    d_hold <= d_rdata;
    starve_cnt <= (reset || !i_req_valid || i_req_ready) ? 3'd0 :
                  (starve_cnt == LIMIT ? LIMIT : starve_cnt + 3'd1);
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed + random checks of the arbiter against a RAM shadow and response scoreboard.
module tb_unified_mem_arbiter;
  logic clk = 0, reset = 1;
  logic i_req_valid = 0, i_req_ready, i_rvalid;
  logic [31:0] i_addr = 0, i_rdata;
  logic d_req_valid = 0, d_req_ready, d_we = 0, d_rvalid;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic [3:0] d_wstrb = 0, mem_we;
  logic mem_en;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0] starve_cnt;
  int n_cmp = 0, n_err = 0;

  unified_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int k);
    return (k == 33) ? 32'h11223344 : (32'hC0DE0000 | 32'(k));
  endfunction

  logic [31:0] ram [0:1023];
  logic [31:0] shadow [0:1023];
  logic [31:0] ram_q;
  bit ram_init;
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int k = 0; k < 1024; k++) ram[k] <= init_word(k);
      ram_init <= 1;
    end else if (mem_en) begin
      ram_q <= ram[mem_addr];
      for (int b = 0; b < 4; b++) if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {logic [1:0] kind; logic [31:0] data;} resp_t;
  resp_t q[$];
  logic [2:0] m_cnt = 0;
  logic [31:0] last_d = 0;
  bit acc_i, acc_d;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    resp_t r;
    logic force_i, exp_ir, exp_dr;
    logic [9:0] a;
    logic [31:0] w;
    @(negedge clk);
    r = (q.size() > 0) ? q.pop_front() : '{2'd0, 32'd0};
    chk("i_rvalid", i_rvalid, r.kind == 2'd1);
    chk("d_rvalid", d_rvalid, r.kind >= 2'd2);
    if (r.kind == 2'd1) chk("i_rdata", i_rdata, r.data);
    if (r.kind >= 2'd2) chk("d_rdata", d_rdata, r.data);
    force_i = i_req_valid && m_cnt == 3'd4;
    exp_ir = i_req_valid && (!d_req_valid || force_i);
    exp_dr = d_req_valid && !force_i;
    chk("starve_cnt", starve_cnt, m_cnt);
    chk("i_req_ready", i_req_ready, exp_ir);
    chk("d_req_ready", d_req_ready, exp_dr);
    chk("mem_en", mem_en, exp_ir || exp_dr);
    if (exp_dr) begin
      a = d_addr[11:2];
      chk("mem_addr_d", mem_addr, a);
      chk("mem_we", mem_we, d_we ? d_wstrb : 4'b0);
      if (d_we) begin
        w = shadow[a];
        for (int b = 0; b < 4; b++) if (d_wstrb[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
        shadow[a] = w;
        q.push_back('{2'd3, last_d});
      end else begin
        q.push_back('{2'd2, shadow[a]});
        last_d = shadow[a];
      end
    end else if (exp_ir) begin
      a = i_addr[11:2];
      chk("mem_addr_i", mem_addr, a);
      chk("mem_we_i", mem_we, 4'b0);
      q.push_back('{2'd1, shadow[a]});
    end else chk("mem_we_idle", mem_we, 4'b0);
    m_cnt = (!i_req_valid || exp_ir) ? 3'd0 : (m_cnt == 3'd4 ? 3'd4 : m_cnt + 3'd1);
    acc_i = exp_ir;
    acc_d = exp_dr;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    chk("rst_i_ready", i_req_ready, 0);
    chk("rst_d_ready", d_req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    q.delete();
    m_cnt = 0;
    last_d = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt [6] = '{0, 1, 2, 3, 4, 0};
    bit iv, dv;
    for (int k = 0; k < 1024; k++) shadow[k] = init_word(k);
    reset = 1;
    reset_cycle();
    reset_cycle();
    reset = 0;
    // sequential fetches
    i_req_valid = 1;
    for (int k = 0; k < 3; k++) begin
      i_addr = 32'(4 * k);
      tick();
    end
    i_req_valid = 0;
    tick();
    // fetch and load collide: data first, fetch next cycle
    i_req_valid = 1; i_addr = 32'h0C;
    d_req_valid = 1; d_we = 0; d_addr = 32'h40;
    tick();
    d_req_valid = 0;
    tick();
    i_req_valid = 0;
    tick();
    // partial store then read back
    d_req_valid = 1; d_we = 1; d_addr = 32'h84; d_wstrb = 4'b0011; d_wdata = 32'hAABBCCDD;
    tick();
    d_we = 0;
    tick();
    d_req_valid = 0;
    tick();
    chk("store_merge", d_rdata, 32'h1122CCDD);
    // starvation of a pending fetch under continuous loads
    i_req_valid = 1; i_addr = 32'h100;
    d_req_valid = 1; d_we = 0; d_addr = 32'h200;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("starve_seq", starve_cnt, 32'(exp_cnt[c]));
      chk("starve_dready", d_req_ready, c != 4);
      tick();
    end
    i_req_valid = 0; d_req_valid = 0;
    tick();
    // reset right after a fetch issues
    i_req_valid = 1; i_addr = 32'h10;
    tick();
    i_req_valid = 0; reset = 1;
    reset_cycle();
    reset = 0;
    i_req_valid = 1; i_addr = 32'h14;
    tick();
    i_req_valid = 0;
    tick();
    // load then store to the same word, then reload
    d_req_valid = 1; d_we = 0; d_addr = 32'h300;
    tick();
    d_we = 1; d_wstrb = 4'hF; d_wdata = 32'h0BADF00D;
    tick();
    d_we = 0;
    tick();
    d_req_valid = 0;
    tick();
    // random traffic with hold-until-ready requesters
    acc_i = 1; acc_d = 1; iv = 0; dv = 0;
    for (int n = 0; n < 60; n++) begin
      if (!iv || acc_i) begin
        iv = 1'($urandom_range(0, 1));
        i_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dv || acc_d) begin
        dv = 1'($urandom_range(0, 3) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        d_wstrb = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      i_req_valid = iv;
      d_req_valid = dv;
      tick();
    end
    i_req_valid = 0; d_req_valid = 0;
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
